// File: rtl/div_issue_ctrl.sv
// Issue-side controller for the iterative divider: accepts one div/rem op, runs the req/resp handshake, holds the result for writeback.
// Optional macro DIV_BYPASS_EN: resolve divide-by-zero at acceptance without using the divider.
module div_issue_ctrl #(
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [63:0]     issue_op1,
    input  logic [63:0]     issue_op2,
    input  logic [2:0]      issue_op,
    input  logic [RD_W-1:0] issue_rd,
    input  logic            flush,
    output logic            div_req_valid,
    input  logic            div_req_ready,
    output logic [63:0]     div_operand1,
    output logic [63:0]     div_operand2,
    output logic [2:0]      div_op,
    input  logic            div_resp_valid,
    input  logic [63:0]     div_resp_result,
    output logic            div_resp_ready,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [RD_W-1:0] wb_rd,
    output logic [63:0]     wb_result,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_e;

    state_e          state_q, state_d;
    logic            drop_q, drop_d;
    logic [63:0]     op1_q, op1_d;
    logic [63:0]     op2_q, op2_d;
    logic [2:0]      op_q, op_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic [63:0]     result_q, result_d;

    logic accept;
    assign issue_ready = (state_q == IDLE) && !flush;
    assign accept      = issue_valid && issue_ready;

`ifdef DIV_BYPASS_EN
    logic        divisor_zero;
    logic [63:0] bypass_result;
    assign divisor_zero  = issue_op[2] ? (issue_op2[31:0] == 32'd0) : (issue_op2 == 64'd0);
    // Architectural divide-by-zero result: all ones for quotients, the dividend for remainders.
    assign bypass_result = !issue_op[1] ? 64'hFFFF_FFFF_FFFF_FFFF :
                           issue_op[2]  ? {{32{issue_op1[31]}}, issue_op1[31:0]} : issue_op1;
`endif

    // NOTE: every variable gets its hold value before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        drop_d   = drop_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        op_d     = op_q;
        rd_d     = rd_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (accept) begin
                    op1_d   = issue_op1;
                    op2_d   = issue_op2;
                    op_d    = issue_op;
                    rd_d    = issue_rd;
                    state_d = REQ;
`ifdef DIV_BYPASS_EN
                    if (divisor_zero) begin
                        result_d = bypass_result;
                        state_d  = WB;
                    end
`endif
                end
            end
            REQ: begin
                // A coincident flush cannot retract a request the divider has already taken.
                if (div_req_ready) begin
                    state_d = WAIT;
                    drop_d  = flush;
                end else if (flush) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (div_resp_valid) begin
                    if (drop_q || flush) begin
                        state_d = IDLE;
                        drop_d  = 1'b0;
                    end else begin
                        result_d = div_resp_result;
                        state_d  = WB;
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            WB: begin
                if (flush || wb_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            drop_q   <= 1'b0;
            // NOTE: datapath registers are reset too, so the operand and result outputs read zero after reset.
            op1_q    <= '0;
            op2_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            drop_q   <= drop_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            result_q <= result_d;
        end
    end

    assign div_req_valid  = (state_q == REQ);
    assign div_resp_ready = (state_q == WAIT);
    assign wb_valid       = (state_q == WB);
    assign busy           = (state_q != IDLE);
    assign div_operand1   = op1_q;
    assign div_operand2   = op2_q;
    assign div_op         = op_q;
    assign wb_rd          = rd_q;
    assign wb_result      = result_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: directed scenarios plus randomized traffic against an operation-level model.
module tb_div_issue_ctrl;

    localparam int RD_W = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            issue_valid = 1'b0;
    logic            issue_ready;
    logic [63:0]     issue_op1 = '0;
    logic [63:0]     issue_op2 = '0;
    logic [2:0]      issue_op = '0;
    logic [RD_W-1:0] issue_rd = '0;
    logic            flush = 1'b0;
    logic            div_req_valid;
    logic            div_req_ready = 1'b0;
    logic [63:0]     div_operand1;
    logic [63:0]     div_operand2;
    logic [2:0]      div_op;
    logic            div_resp_valid = 1'b0;
    logic [63:0]     div_resp_result = '0;
    logic            div_resp_ready;
    logic            wb_valid;
    logic            wb_ready = 1'b1;
    logic [RD_W-1:0] wb_rd;
    logic [63:0]     wb_result;
    logic            busy;

    always #5 clk = ~clk;

    div_issue_ctrl #(.RD_W(RD_W)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op1(issue_op1), .issue_op2(issue_op2), .issue_op(issue_op), .issue_rd(issue_rd),
        .flush(flush),
        .div_req_valid(div_req_valid), .div_req_ready(div_req_ready),
        .div_operand1(div_operand1), .div_operand2(div_operand2), .div_op(div_op),
        .div_resp_valid(div_resp_valid), .div_resp_result(div_resp_result), .div_resp_ready(div_resp_ready),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_result(wb_result),
        .busy(busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // RISC-V M-extension divide/remainder semantics.
    function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op);
        logic [31:0] a32, b32, r32;
        logic [63:0] r;
        if (op[2]) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'd0)                                 r32 = op[1] ? a32 : 32'hFFFF_FFFF;
            else if (op[0])                                   r32 = op[1] ? a32 % b32 : a32 / b32;
            else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = op[1] ? 32'd0 : a32;
            else if (op[1])                                   r32 = $signed(a32) % $signed(b32);
            else                                              r32 = $signed(a32) / $signed(b32);
            r = {{32{r32[31]}}, r32};
        end else begin
            if (b == 64'd0)                                   r = op[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
            else if (op[0])                                   r = op[1] ? a % b : a / b;
            else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r = op[1] ? 64'd0 : a;
            else if (op[1])                                   r = $signed(a) % $signed(b);
            else                                              r = $signed(a) / $signed(b);
        end
        return r;
    endfunction

    function automatic bit zero_div(input logic [63:0] b, input logic [2:0] op);
        return op[2] ? (b[31:0] == 32'd0) : (b == 64'd0);
    endfunction

    // Operation-level model: one pending op with phase flags, plus the divider's outstanding request.
    bit              pend, pend_req, pend_res, occ;
    logic [63:0]     m_op1, m_op2, m_res;
    logic [2:0]      m_op;
    logic [RD_W-1:0] m_rd;
    bit              dv_busy;
    int              dv_cnt;
    logic [63:0]     dv_res;
    int              fixed_lat = -1;
    int              rdy_pct   = 60;
    int              n_wb      = 0;

    always @(negedge clk) begin
        if (rst) begin
            pend    = 1'b0;
            dv_busy = 1'b0;
        end else begin
            occ = pend || dv_busy;
            check("busy", busy, occ);
            check("issue_ready", issue_ready, !occ && !flush);
            check("div_req_valid", div_req_valid, pend && !pend_req && !pend_res);
            check("div_resp_ready", div_resp_ready, dv_busy);
            check("wb_valid", wb_valid, pend && pend_res);
            if (pend && !pend_req && !pend_res) begin
                check("div_operand1", div_operand1, m_op1);
                check("div_operand2", div_operand2, m_op2);
                check("div_op", div_op, m_op);
            end
            if (pend && pend_res) begin
                check("wb_rd", wb_rd, m_rd);
                check("wb_result", wb_result, m_res);
            end
            if (dv_busy && dv_cnt > 0) dv_cnt--;
            if (wb_valid && wb_ready && !flush) begin
                n_wb++;
                pend = 1'b0;
            end
            if (div_resp_valid && div_resp_ready) begin
                dv_busy = 1'b0;
                if (pend) pend_res = 1'b1;
            end
            if (div_req_valid && div_req_ready) begin
                dv_busy = 1'b1;
                dv_res  = ref_div(div_operand1, div_operand2, div_op);
                dv_cnt  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(4));
                if (pend) pend_req = 1'b1;
            end
            if (flush) pend = 1'b0;
            if (issue_valid && issue_ready) begin
                pend     = 1'b1;
                pend_req = 1'b0;
                pend_res = 1'b0;
                m_op1    = issue_op1;
                m_op2    = issue_op2;
                m_op     = issue_op;
                m_rd     = issue_rd;
                m_res    = ref_div(issue_op1, issue_op2, issue_op);
`ifdef DIV_BYPASS_EN
                if (zero_div(issue_op2, issue_op)) pend_res = 1'b1;
`endif
            end
        end
    end

    // Divider model, shares rst with the controller.
    always @(posedge clk) begin
        #1;
        div_req_ready   = !dv_busy && ($urandom_range(99) < rdy_pct);
        div_resp_valid  = dv_busy && (dv_cnt == 0);
        div_resp_result = dv_busy ? dv_res : {$urandom, $urandom};
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [2:0] op, input logic [RD_W-1:0] rd);
        int n;
        issue_valid = 1'b1;
        issue_op1 = a;
        issue_op2 = b;
        issue_op  = op;
        issue_rd  = rd;
        n = 0;
        while (!issue_ready && n < 50) begin
            cyc();
            n++;
        end
        if (n >= 50) check("issue_timeout", 1'b0, 1'b1);
        cyc();
        issue_valid = 1'b0;
    endtask

    task automatic wait_until(input string tag, input int which);
        int n;
        n = 0;
        while (n < 60 && !((which == 0 && wb_valid) || (which == 1 && div_resp_ready) ||
                           (which == 2 && div_resp_valid) || (which == 3 && !busy))) begin
            cyc();
            n++;
        end
        if (n >= 60) check(tag, 1'b0, 1'b1);
    endtask

    initial begin
        repeat (2) cyc();
        rst = 1'b0;
        cyc();

        // Plain DIV
        rdy_pct = 100;
        fixed_lat = 2;
        issue(64'd100, 64'd7, 3'b000, 5'd5);
        check("div_req_at_T1", div_req_valid, 1'b1);
        wait_until("div_wb_timeout", 0);
        check("div_wb_rd", wb_rd, 5'd5);
        check("div_wb_result", wb_result, 64'd14);
        cyc();

        // REMUW under writeback backpressure
        wb_ready = 1'b0;
        issue(64'h1_0000_0007, 64'd3, 3'b111, 5'd9);
        wait_until("remuw_wb_timeout", 0);
        for (int i = 0; i < 10; i++) begin
            check("remuw_hold_valid", wb_valid, 1'b1);
            check("remuw_hold_result", wb_result, 64'd1);
            check("remuw_hold_ready", issue_ready, 1'b0);
            cyc();
        end
        wb_ready = 1'b1;
        cyc();
        check("ready_after_wb", issue_ready, 1'b1);

        // Flush while waiting for the response, then a clean op
        fixed_lat = 8;
        issue(64'd55, 64'd11, 3'b000, 5'd7);
        wait_until("wait_state_timeout", 1);
        repeat (2) cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("drain_resp_ready", div_resp_ready, 1'b1);
        wait_until("drain_timeout", 3);
        check("drain_no_wb", wb_valid, 1'b0);
        issue(64'd20, 64'd4, 3'b000, 5'd6);
        wait_until("after_flush_wb_timeout", 0);
        check("after_flush_result", wb_result, 64'd5);
        cyc();

        // Flush in REQ without handshake
        rdy_pct = 0;
        issue(64'd9, 64'd2, 3'b000, 5'd4);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("req_flush_valid", div_req_valid, 1'b0);
        check("req_flush_busy", busy, 1'b0);

        // Flush coinciding with the response
        rdy_pct = 100;
        fixed_lat = 3;
        issue(64'd90, 64'd9, 3'b000, 5'd4);
        wait_until("resp_timeout", 2);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check("resp_flush_wb", wb_valid, 1'b0);
        check("resp_flush_busy", busy, 1'b0);

        // Divide by zero
        issue(64'd55, 64'd0, 3'b001, 5'd1);
`ifdef DIV_BYPASS_EN
        check("byp_divu_wb_T1", wb_valid, 1'b1);
        check("byp_divu_noreq", div_req_valid, 1'b0);
`endif
        wait_until("divu0_timeout", 0);
        check("divu0_result", wb_result, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc();
        issue(64'h8000_0005, 64'h1_0000_0000, 3'b110, 5'd2);
`ifdef DIV_BYPASS_EN
        check("byp_remw_wb_T1", wb_valid, 1'b1);
`endif
        wait_until("remw0_timeout", 0);
        check("remw0_result", wb_result, 64'hFFFF_FFFF_8000_0005);
        cyc();

        // Reset while waiting
        fixed_lat = 20;
        issue(64'd77, 64'd5, 3'b000, 5'd3);
        wait_until("rst_wait_timeout", 1);
        rst = 1'b1;
        cyc();
        check("rst_req_valid", div_req_valid, 1'b0);
        check("rst_resp_ready", div_resp_ready, 1'b0);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_operand1", div_operand1, 64'd0);
        check("rst_operand2", div_operand2, 64'd0);
        check("rst_op", div_op, 3'd0);
        check("rst_wb_rd", wb_rd, 5'd0);
        check("rst_wb_result", wb_result, 64'd0);
        rst = 1'b0;
        cyc();
        check("rst_issue_ready", issue_ready, 1'b1);

        // Randomized traffic
        fixed_lat = -1;
        rdy_pct = 60;
        n_wb = 0;
        for (int i = 0; i < 3000; i++) begin
            int sel;
            issue_valid = 1'($urandom_range(1));
            issue_op    = 3'($urandom_range(7));
            issue_rd    = RD_W'($urandom);
            issue_op1   = {$urandom, $urandom};
            sel = int'($urandom_range(9));
            case (sel)
                0: issue_op2 = 64'd0;
                1: issue_op2 = {$urandom, 32'd0};
                2: begin
                    issue_op1 = issue_op[2] ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
                    issue_op2 = 64'hFFFF_FFFF_FFFF_FFFF;
                end
                3, 4, 5: issue_op2 = 64'($urandom_range(1, 100));
                default: issue_op2 = {$urandom, $urandom};
            endcase
            flush    = ($urandom_range(19) == 0);
            wb_ready = ($urandom_range(9) < 6);
            rst      = ($urandom_range(299) == 0);
            cyc();
        end
        issue_valid = 1'b0;
        flush = 1'b0;
        rst = 1'b0;
        wb_ready = 1'b1;
        rdy_pct = 100;
        repeat (30) cyc();
        check("final_idle", busy, 1'b0);
        check("random_wb_seen", n_wb > 50, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
Name: div_issue_ctrl

Overview:
- Initiator-side controller between the integer issue stage and the iterative divider's req/resp handshake.
- Accepts one divide/remainder instruction at a time and drives the divider request.
- Consumes the divider response and presents the result with its destination register to writeback.
- Handles pipeline flush of an in-flight operation by draining and discarding the response.

Parameters:
- RD_W, 5, destination register index width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- issue_valid  in  1  instruction offered by issue stage
- issue_ready  out  1  controller can accept
- issue_op1  in  64  dividend
- issue_op2  in  64  divisor
- issue_op  in  3  bit0 unsigned, bit1 remainder, bit2 word (W-form)
- issue_rd  in  RD_W  destination register
- flush  in  1  kill any accepted, not-yet-written-back op
- div_req_valid  out  1  request to divider
- div_req_ready  in  1  divider accepts
- div_operand1  out  64  registered dividend
- div_operand2  out  64  registered divisor
- div_op  out  3  registered issue_op
- div_resp_valid  in  1  divider result valid
- div_resp_result  in  64  divider result
- div_resp_ready  out  1  controller consumes result
- wb_valid  out  1  result available to writeback
- wb_ready  in  1  writeback accepts
- wb_rd  out  RD_W  destination register
- wb_result  out  64  result
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, REQ, WAIT, WB. Internal drop flag.
- Reset: state IDLE, drop=0. All outputs 0: div_req_valid, div_resp_ready, wb_valid, busy, and all data regs.
- Reset mid-operation: return to IDLE immediately, no writeback. The divider shares rst, so no stale response arrives.
- issue_ready = (state==IDLE) && !flush. Combinational, no dependence on issue_valid.
- IDLE, on issue_valid && issue_ready:
  - Latch op1/op2/op/rd.
  - Go to REQ; div_req_valid=1 from the next cycle.
- REQ:
  - div_req_valid=1; operands stable while waiting.
  - div_req_ready=1 && !flush: go to WAIT.
  - flush: go to IDLE, div_req_valid=0 next cycle, request never handshaken. If flush and div_req_ready coincide, the request is already taken: go to WAIT with drop=1.
- WAIT:
  - div_resp_ready=1.
  - flush: set drop=1.
  - div_resp_valid with drop=1 (including flush in the same cycle): consume, go to IDLE, clear drop, no wb_valid.
  - Otherwise capture div_resp_result into wb_result and go to WB.
- WB:
  - wb_valid=1; wb_rd/wb_result stable until handshake.
  - wb_ready: go to IDLE; wb_valid=0 next cycle.
  - flush, with or without wb_ready: go to IDLE, result discarded. Flush has priority.
- No back-to-back overlap: a new issue is accepted only in IDLE, so minimum spacing is acceptance → WB handshake → next cycle.
- Latency:
  - Accept at cycle T; div_req_valid at T+1.
  - wb_valid asserts the cycle after the response handshake.
- rd==0 is handled like any other rd; writeback ignores it.
- busy = state != IDLE, registered-state derived.

Optional Feature:
- Macro: DIV_BYPASS_EN.
- Defined: at acceptance, check for divide-by-zero. The divisor is zero when issue_op2==0, or issue_op2[31:0]==0 for word ops. On zero, skip REQ/WAIT and go straight to WB with:
  - quotient ops: 64'hFFFF_FFFF_FFFF_FFFF;
  - remainder ops: op1, or {{32{op1[31]}}, op1[31:0]} for word ops.
  - wb_valid at T+1. div_req_valid never asserts.
- Undefined: all ops go through the divider; identical architectural results, longer latency.

Test Plan:
- DIV: issue 100, 7, op=000, rd=5 → one div_req handshake with 100/7/000; divider returns 14 → wb_valid next cycle, wb_rd=5, wb_result=14.
- REMUW backpressure: issue 0x1_0000_0007, 3, op=111; hold wb_ready=0 for 10 cycles → wb_valid held high with stable result 1; issue_ready=0 throughout; accepts a new op the cycle after the wb handshake.
- Flush in WAIT: flush 3 cycles after req handshake → div_resp_ready stays 1, response consumed, no wb_valid, busy drops; the next issue (20/4 → 5) writes back correctly.
- Flush in REQ with div_req_ready=0 → div_req_valid=0 next cycle, state IDLE. Flush concurrent with div_resp_valid → no wb_valid.
- Divide-by-zero: DIVU 55/0 → 0xFFFF_FFFF_FFFF_FFFF. REMW 0x8000_0005/0 → 0xFFFF_FFFF_8000_0005. With DIV_BYPASS_EN: wb_valid at T+1 and no div_req_valid. Without: same values via the divider.
- Reset asserted in WAIT → next cycle all outputs 0, state IDLE, issue_ready=1 after rst deasserts.
